sap1_ram16x8: RTL and testbench
===============================

Name: sap1_ram16x8

Overview:
- 16x8 program/data memory of the SAP-1 datapath, directly downstream of the memory address register (MAR).
- The MAR's 4-bit output drives `addr`. When `ce` is low and the block is in run mode, the addressed word is presented for the W-bus.
- In program mode, an external loader (switch panel or UART front-end) writes words through a valid/ready handshake.
- A synchronous clear sweeps every location to a known value before the block reports itself usable.

Parameters:
- `DATA_W`, 8, word width.
- `ADDR_W`, 4, address width; depth is 2**ADDR_W.
- `CLEAR_VAL`, 8'h00, value written to every location by the clear sweep.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `addr`  in  ADDR_W  read address from the MAR output `q`.
- `ce`  in  1  active-low output enable from the controller (0 = drive word).
- `data_out`  out  DATA_W  read data toward the W-bus.
- `out_en`  out  1  high when `data_out` is valid and may be placed on the bus; the bus mux or tristate lives outside this block.
- `prog`  in  1  1 = program mode, 0 = run mode.
- `wr_valid`  in  1  loader has a word to write.
- `wr_addr`  in  ADDR_W  loader write address.
- `wr_data`  in  DATA_W  loader write data.
- `wr_ready`  out  1  block can accept a write this cycle.
- `busy`  out  1  clear sweep in progress.

Behaviour:
- Reset is synchronous and active-high on `clr`, sampled at the rising edge of `clk`.
- FSM states: CLEAR, READY, WACK. Sweep pointer `ptr` is ADDR_W bits.
- `clr`=1 at any edge, in any state:
  - state goes to CLEAR and `ptr` goes to 0;
  - no loader write occurs that cycle, even with `wr_valid` and `wr_ready` both high.
- CLEAR:
  - each cycle writes `CLEAR_VAL` to mem[`ptr`], then increments `ptr`;
  - after the write at `ptr`=2**ADDR_W-1, `ptr` wraps to 0 and state goes to READY;
  - the sweep takes exactly 16 cycles after `clr` drops;
  - `busy`=1, `wr_ready`=0, `out_en`=0 throughout.
  - `clr` held high keeps the block parked in CLEAR with `ptr`=0; no sweep progress is made.
- READY:
  - `wr_ready` = `prog`, combinational.
  - On an edge with `prog`, `wr_valid` and `wr_ready` all high: mem[`wr_addr`] <= `wr_data`, then state goes to WACK.
- WACK:
  - `wr_ready`=0 for exactly one cycle, then state returns to READY.
  - Maximum write rate is one word per 2 cycles.
- Handshake rules:
  - `wr_valid` without `wr_ready` causes no write; the loader must hold `addr`/`data` until accepted.
  - If `prog` falls while `wr_valid` is pending, the write is dropped.
- Read path is combinational, with zero latency:
  - `out_en` = (`ce`==0) && !`prog` && state!=CLEAR;
  - `data_out` = `out_en` ? mem[`addr`] : {DATA_W{1'b0}}.
- Write-then-read to the same address in the same cycle returns the old word; the new word is visible from the next cycle.
- Reset values:
  - `busy`=1 and `wr_ready`=0 from the edge at which `clr` is sampled high;
  - `out_en`=0 and `data_out`=0 during CLEAR;
  - memory contents are undefined until the sweep completes.

Optional Feature:
- Macro: `SAP1_RAM_PRELOAD_EN`.
- Defined: the CLEAR sweep writes a built-in demo program instead of `CLEAR_VAL`:
  - addr 0: 8'h09 (LDA 9)
  - addr 1: 8'h1A (ADD A)
  - addr 2: 8'h2B (SUB B)
  - addr 3: 8'hE0 (OUT)
  - addr 4: 8'hF0 (HLT)
  - addr 9: 8'h10
  - addr A: 8'h14
  - addr B: 8'h18
  - every other address: `CLEAR_VAL`
- Sweep timing and ports are unchanged.
- Undefined: every location is written with `CLEAR_VAL`.

Decomposition:
- Shared package `sap1_pkg`:
  - `ADDR_W`/`DATA_W` constants;
  - opcode constants (LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF);
  - the RAM FSM state enum;
  - preload-table function mapping address to word.
- One sub-module, `sap1_ram_array`: 2**ADDR_W x DATA_W register file with one synchronous write port and one asynchronous read port.
- The FSM and read gating stay in the top module.

Test Plan:
- Pulse `clr` for 1 cycle → `busy`=1 for exactly 16 cycles, then 0. With `prog`=0, `ce`=0, read addr 0..15 → each gives `data_out`=8'h00 and `out_en`=1.
- `prog`=1, `wr_valid`=1, `wr_addr`=4'h5, `wr_data`=8'hA7 → accepted on first READY edge; `wr_ready`=0 next cycle. Then `prog`=0, `ce`=0, `addr`=5 → `data_out`=8'hA7.
- Back-to-back writes to 3 and 4 with `wr_valid` held high → exactly 2 writes across 4 cycles; `wr_ready` toggles 1,0,1,0.
- `ce`=1, or `prog`=1 → `out_en`=0 and `data_out`=8'h00 for any `addr`.
- Assert `clr` mid-sweep at `ptr`=7, and separately in WACK with `wr_valid`=1 → sweep restarts at 0 and needs a full 16 cycles; no write occurs in the `clr` cycle; memory reads all 8'h00 afterwards.
- With `SAP1_RAM_PRELOAD_EN`: after the sweep, addr 0..4 read 09, 1A, 2B, E0, F0, and addr 9 reads 8'h10.

Source files
------------

// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared SAP-1 constants, RAM FSM state type and demo-program table
package sap1_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_READY = 2'd1,
        ST_WACK  = 2'd2
    } ram_state_t;

    // Demo program: A = mem[9] + mem[A] - mem[B], print it, halt.
    function automatic logic [DATA_W-1:0] preload_word(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] fill
    );
        case (a)
            4'h0:    return {OP_LDA, 4'h9};
            4'h1:    return {OP_ADD, 4'hA};
            4'h2:    return {OP_SUB, 4'hB};
            4'h3:    return {OP_OUT, 4'h0};
            4'h4:    return {OP_HLT, 4'h0};
            4'h9:    return 8'h10;
            4'hA:    return 8'h14;
            4'hB:    return 8'h18;
            default: return fill;
        endcase
    endfunction

endpackage

// File: rtl/sap1_ram_array.sv
// rtl/sap1_ram_array.sv - 2**ADDR_W x DATA_W register file, sync write, async read
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
module sap1_ram_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // No reset on the storage; the top-level clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sap1_ram16x8.sv
// rtl/sap1_ram16x8.sv - SAP-1 16x8 program/data RAM with loader handshake and clear sweep
// Ports: clk, clr (sync active-high); addr/ce -> data_out/out_en read path;
//        prog, wr_valid/wr_addr/wr_data -> wr_ready loader port; busy during sweep.
// Build option: SAP1_RAM_PRELOAD_EN makes the sweep load a demo program.
module sap1_ram16x8 #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 4,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ce,
    output logic [DATA_W-1:0] data_out,
    output logic              out_en,
    input  logic              prog,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy
);

    import sap1_pkg::*;

    localparam int PKG_AW = sap1_pkg::ADDR_W;
    localparam int PKG_DW = sap1_pkg::DATA_W;

    ram_state_t        state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] sweep_data;
    logic [DATA_W-1:0] rdata;

`ifdef SAP1_RAM_PRELOAD_EN
    assign sweep_data = DATA_W'(preload_word(PKG_AW'(ptr), PKG_DW'(CLEAR_VAL)));
`else
    assign sweep_data = CLEAR_VAL;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Every write is gated by !clr so a clr edge never commits a loader
    // word or advances the sweep.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        we         = 1'b0;
        waddr      = wr_addr;
        wdata      = wr_data;
        wr_ready   = 1'b0;
        case (state)
            ST_CLEAR: begin
                we       = !clr;
                waddr    = ptr;
                wdata    = sweep_data;
                ptr_next = ptr + ADDR_W'(1);
                if (ptr == {ADDR_W{1'b1}}) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                wr_ready = prog;
                if (prog && wr_valid) begin
                    we         = !clr;
                    state_next = ST_WACK;
                end
            end
            ST_WACK: begin
                state_next = ST_READY;
            end
            default: begin
                state_next = ST_CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    sap1_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (addr),
        .rdata (rdata)
    );

    assign busy     = (state == ST_CLEAR);
    assign out_en   = !ce && !prog && (state != ST_CLEAR);
    assign data_out = out_en ? rdata : '0;

endmodule

// File: tb/tb_sap1_ram16x8.sv
// tb/tb_sap1_ram16x8.sv - scoreboard bench for sap1_ram16x8 with behavioural model
module tb_sap1_ram16x8;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] addr = '0;
    logic       ce = 1'b1;
    logic [7:0] data_out;
    logic       out_en;
    logic       prog = 1'b0;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sap1_ram16x8 dut (
        .clk      (clk),
        .clr      (clr),
        .addr     (addr),
        .ce       (ce),
        .data_out (data_out),
        .out_en   (out_en),
        .prog     (prog),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy)
    );

    typedef struct {
        logic       busy;
        logic       wr_ready;
        logic       out_en;
        logic [7:0] data;
        bit         chk_data;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model: remaining sweep cycles, one-cycle write cooldown,
    // and an array of words that is only trusted after a full sweep.
    bit         m_state_known = 0;
    int         m_sweep_left  = 0;
    bit         m_cooldown    = 0;
    bit         m_mem_known   = 0;
    logic [7:0] m_mem [16];

    function automatic logic [7:0] swept_word(input int a);
`ifdef SAP1_RAM_PRELOAD_EN
        case (a)
            0: return 8'h09;
            1: return 8'h1A;
            2: return 8'h2B;
            3: return 8'hE0;
            4: return 8'hF0;
            9: return 8'h10;
            10: return 8'h14;
            11: return 8'h18;
            default: return 8'h00;
        endcase
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_edge();
        if (clr) begin
            m_state_known = 1;
            m_sweep_left  = 16;
            m_cooldown    = 0;
            m_mem_known   = 0;
        end else if (m_sweep_left > 0) begin
            m_sweep_left = m_sweep_left - 1;
            if (m_sweep_left == 0) begin
                for (int i = 0; i < 16; i++) m_mem[i] = swept_word(i);
                m_mem_known = 1;
            end
        end else if (m_cooldown) begin
            m_cooldown = 0;
        end else if (prog && wr_valid) begin
            m_mem[wr_addr] = wr_data;
            m_cooldown     = 1;
        end
    endtask

    function automatic bit model_ready();
        return (m_sweep_left == 0) && !m_cooldown && prog;
    endfunction

    // Drive one cycle: set inputs, queue the expected outputs for this
    // cycle, then advance the model at the clock edge.
    task automatic drive(input logic c, input logic p, input logic e, input logic [3:0] a,
                         input logic v, input logic [3:0] wa, input logic [7:0] wd);
        exp_t x;
        clr = c; prog = p; ce = e; addr = a;
        wr_valid = v; wr_addr = wa; wr_data = wd;
        if (m_state_known) begin
            x.busy     = (m_sweep_left > 0);
            x.wr_ready = model_ready();
            x.out_en   = !e && !p && (m_sweep_left == 0);
            x.data     = x.out_en ? m_mem[a] : 8'h00;
            x.chk_data = !x.out_en || m_mem_known;
            exp_q.push_back(x);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic read(input logic [3:0] a);
        drive(1'b0, 1'b0, 1'b0, a, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        bit done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            done = model_ready();
            drive(1'b0, 1'b1, 1'b1, 4'($urandom), 1'b1, a, d);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL write_accept: got not accepted required accepted within 8 cycles");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) read(4'($urandom));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            if (busy !== x.busy) begin
                errors++;
                $display("FAIL busy @%0t: got %b required %b", $time, busy, x.busy);
            end
            checks++;
            if (wr_ready !== x.wr_ready) begin
                errors++;
                $display("FAIL wr_ready @%0t: got %b required %b", $time, wr_ready, x.wr_ready);
            end
            checks++;
            if (out_en !== x.out_en) begin
                errors++;
                $display("FAIL out_en @%0t: got %b required %b", $time, out_en, x.out_en);
            end
            if (x.chk_data) begin
                checks++;
                if (data_out !== x.data) begin
                    errors++;
                    $display("FAIL data_out @%0t: got %h required %h", $time, data_out, x.data);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;

        // Reset pulse, full sweep, then read every address.
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
        idle(16);
        for (int i = 0; i < 16; i++) read(4'(i));

        // Single write then read back.
        write_word(4'h5, 8'hA7);
        drive(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
        read(4'h5);

        // Back-to-back writes with wr_valid held high.
        drive(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 4'h3, 8'h33);
        drive(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 4'h3, 8'h33);
        drive(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 4'h4, 8'h44);
        drive(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 4'h4, 8'h44);
        read(4'h3);
        read(4'h4);

        // Read gating: ce high or prog high.
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 4'($urandom), 1'b0, 4'h0, 8'h00);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 4'($urandom), 1'b0, 4'h0, 8'h00);

        // Write dropped when prog falls while wr_valid is pending.
        drive(1'b0, 1'b0, 1'b0, 4'h6, 1'b1, 4'h6, 8'h5A);
        read(4'h6);

        // clr mid-sweep at ptr 7.
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
        idle(7);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
        idle(16);
        for (int i = 0; i < 16; i++) read(4'(i));

        // clr during WACK with wr_valid high, and clr in READY with a valid write.
        write_word(4'h8, 8'hC3);
        drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 4'h9, 8'h99);
        idle(16);
        write_word(4'h2, 8'h22);
        drive(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 4'h7, 8'h77);
        idle(16);
        for (int i = 0; i < 16; i++) read(4'(i));

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                  4'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
        end
        idle(20);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
